// File: rtl/usb_tx_packetizer.sv
// usb_tx_packetizer: builds USB full-speed handshake/data packets (SYNC, PID, payload, CRC16, EOP)
// with bit stuffing and NRZI onto D+/D-.
module usb_tx_packetizer #(
    parameter int CLKS_PER_BIT = 8,
    parameter int MAX_PAYLOAD  = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [2:0] tx_packet,
    input  logic [6:0] buffer_occupancy,
    input  logic [7:0] tx_packet_data,
    output logic       get_tx_packet_data,
    output logic       dplus_out,
    output logic       dminus_out,
    output logic       tx_transfer_active,
    output logic       tx_done,
    output logic       tx_error
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    typedef enum logic [2:0] {IDLE, SYNC, PID, DATA, CRC, EOP} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0] idx, idx_n, pid_code;
    logic [6:0] bytes, bytes_n;
    logic [7:0] pid, pid_n, shreg, shreg_n;
    logic [15:0] crc, crc_n, crc_step;
    logic [2:0] ones, ones_n;
    logic stuffing, stuffing_n, level, level_n, is_data, is_data_n, done_n, error_n;
    logic data_req, accept, cur_bit, line_bit, nrzi, bit_end, last, stuff_now;

    assign data_req = tx_packet == 3'd1 || tx_packet == 3'd2;
    assign accept = tx_packet != 3'd0 && tx_packet < 3'd6 && !(data_req && buffer_occupancy > 7'(MAX_PAYLOAD));
    assign pid_code = tx_packet == 3'd1 ? 4'b0011 : tx_packet == 3'd2 ? 4'b1011 :
                      tx_packet == 3'd3 ? 4'b0010 : tx_packet == 3'd4 ? 4'b1010 : 4'b1110;
    assign get_tx_packet_data = state == DATA && idx == 4'd0 && cnt == '0 && !stuffing;
    assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
    assign last = state == CRC ? idx == 4'd15 : idx == 4'd7;
    // Bit 0 of each byte is taken straight from the buffer in the pop cycle, later cycles use the captured copy.
    assign cur_bit = state == SYNC ? idx == 4'd7 :
                     state == PID  ? pid[idx[2:0]] :
                     state == DATA ? (get_tx_packet_data ? tx_packet_data[0] : shreg[idx[2:0]]) :
                     state == CRC  ? ~crc[4'd15 - idx] : 1'b0;
    assign line_bit = cur_bit & ~stuffing;
    assign nrzi = line_bit ? level : ~level;
    assign stuff_now = !stuffing && cur_bit && ones == 3'd5;
    assign crc_step = {crc[14:0], 1'b0} ^ ((crc[15] ^ cur_bit) ? 16'h8005 : 16'h0000);
    assign dplus_out = state == IDLE ? 1'b1 : state == EOP ? idx == 4'd2 : nrzi;
    assign dminus_out = state != IDLE && state != EOP && !nrzi;
    assign tx_transfer_active = state != IDLE;

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        idx_n = idx;
        bytes_n = bytes;
        pid_n = pid;
        shreg_n = get_tx_packet_data ? tx_packet_data : shreg;
        crc_n = crc;
        ones_n = ones;
        stuffing_n = stuffing;
        level_n = level;
        is_data_n = is_data;
        done_n = 1'b0;
        error_n = 1'b0;
        if (state == IDLE) begin
            cnt_n = '0;
            idx_n = '0;
            ones_n = '0;
            stuffing_n = 1'b0;
            level_n = 1'b1;
            error_n = tx_start && !accept;
            if (tx_start && accept) begin
                state_n = SYNC;
                pid_n = {~pid_code, pid_code};
                is_data_n = data_req;
                bytes_n = buffer_occupancy;
            end
        end else if (bit_end) begin
            cnt_n = '0;
            if (state == EOP) begin
                idx_n = idx + 4'd1;
                if (idx == 4'd2) begin
                    state_n = IDLE;
                    done_n = 1'b1;
                end
            end else if (stuff_now) begin
                // Field position is held so the stuff bit slots in before the next data bit.
                level_n = nrzi;
                stuffing_n = 1'b1;
                ones_n = 3'd0;
                if (state == DATA) crc_n = crc_step;
            end else begin
                level_n = nrzi;
                stuffing_n = 1'b0;
                ones_n = line_bit ? ones + 3'd1 : 3'd0;
                if (state == DATA && !stuffing) crc_n = crc_step;
                idx_n = last ? 4'd0 : idx + 4'd1;
                if (last) begin
                    state_n = state == SYNC ? PID :
                              state == PID  ? (!is_data ? EOP : bytes == 7'd0 ? CRC : DATA) :
                              state == DATA ? (bytes == 7'd1 ? CRC : DATA) : EOP;
                    if (state == SYNC) crc_n = 16'hFFFF;
                    if (state == DATA) bytes_n = bytes - 7'd1;
                    if (state_n == EOP) level_n = 1'b1;
                end
            end
        end else begin
            cnt_n = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            idx <= '0;
            bytes <= '0;
            pid <= '0;
            shreg <= '0;
            crc <= '0;
            ones <= '0;
            stuffing <= 1'b0;
            level <= 1'b1;
            is_data <= 1'b0;
            tx_done <= 1'b0;
            tx_error <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            idx <= idx_n;
            bytes <= bytes_n;
            pid <= pid_n;
            shreg <= shreg_n;
            crc <= crc_n;
            ones <= ones_n;
            stuffing <= stuffing_n;
            level <= level_n;
            is_data <= is_data_n;
            tx_done <= done_n;
            tx_error <= error_n;
        end
    end
endmodule
